// File: rtl/img_pkg.sv
// Shared definitions for the image memory reader: memory geometry,
// controller states and the wrapping address increment.
package img_pkg;

    localparam int IMG_ADDR_W = 17;
    localparam int IMG_DATA_W = 8;
    localparam int IMG_DEPTH  = 81920;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FIN
    } state_t;

    // Next word address; the last word of the memory is followed by word 0.
    function automatic logic [IMG_ADDR_W-1:0] next_addr(
        input logic [IMG_ADDR_W-1:0] addr,
        input int                    depth
    );
        if (addr == IMG_ADDR_W'(depth - 1)) begin
            return '0;
        end
        return addr + IMG_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/img_sync_fifo.sv
// Synchronous FIFO with exact full/empty and occupancy count. DEPTH must be
// a power of two so the pointers wrap on their own.
module img_sync_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointer and count update; a simultaneous push and pop leaves count alone.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples values from before the edge, independent of block order.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port.
    // NOTE: the data array is deliberately not reset; an empty count already
    // marks every entry invalid, and leaving it out lets it map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/image_mem_reader.sv
// Avalon-MM read master for an image memory (read latency 1) that streams a
// contiguous run of pixels out of an Avalon-ST source as a single packet.
module image_mem_reader
    import img_pkg::*;
#(
    parameter int ADDR_W     = IMG_ADDR_W,
    parameter int DATA_W     = IMG_DATA_W,
    parameter int MEM_DEPTH  = IMG_DEPTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_clken,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]  num_words_q, num_words_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  deliver_cnt_q, deliver_cnt_d;
    logic              inflight_q, inflight_d;

    logic [FCNT_W-1:0] fifo_count;
    logic [FCNT_W-1:0] occupancy;
    logic              fifo_full, fifo_empty;
    logic              pop, can_issue;

    // Return-data buffer: a read issued last cycle lands here unconditionally.
    img_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight_q),
        .pop   (pop),
        .din   (m_readdata),
        .dout  (st_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign m_clken     = 1'b1;
    assign m_write     = 1'b0;
    assign m_writedata = '0;
    assign m_address   = cur_addr_q;

    assign st_valid = ~fifo_empty;
    assign pop      = st_valid & st_ready;
    assign st_sop   = st_valid & (deliver_cnt_q == num_words_q);
    assign st_eop   = st_valid & (deliver_cnt_q == CNT_W'(1));

    // Buffered pixels plus the one possibly still in flight must leave room
    // for another read, so the buffer can never overflow.
    assign occupancy = fifo_count + FCNT_W'(inflight_q);
    assign can_issue = ~fifo_full & (occupancy < FCNT_W'(FIFO_DEPTH));

    // Controller next state, read issue and status outputs.
    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        num_words_d   = num_words_q;
        issue_cnt_d   = issue_cnt_q;
        deliver_cnt_d = pop ? deliver_cnt_q - CNT_W'(1) : deliver_cnt_q;
        m_chipselect  = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_addr_d    = base_addr;
                    num_words_d   = num_words;
                    issue_cnt_d   = num_words;
                    deliver_cnt_d = num_words;
                    state_d       = (num_words == '0) ? FIN : READ;
                end
            end
            READ: begin
                busy = 1'b1;
                if (can_issue) begin
                    m_chipselect = 1'b1;
                    cur_addr_d   = next_addr(cur_addr_q, MEM_DEPTH);
                    issue_cnt_d  = issue_cnt_q - CNT_W'(1);
                    if (issue_cnt_q == CNT_W'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // Every captured pixel is counted in deliver_cnt, so the count
                // reaching zero on this pop also means the buffer is empty.
                if (deliver_cnt_d == '0) state_d = FIN;
            end
            FIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        inflight_d = m_chipselect;
    end

    // Controller registers; reset aborts any transfer and drops in-flight data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cur_addr_q    <= '0;
            num_words_q   <= '0;
            issue_cnt_q   <= '0;
            deliver_cnt_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            num_words_q   <= num_words_d;
            issue_cnt_q   <= issue_cnt_d;
            deliver_cnt_q <= deliver_cnt_d;
            inflight_q    <= inflight_d;
        end
    end

endmodule
